// File: rtl/timer_pkg.sv
// Shared definitions for the timer/stopwatch/display blocks.
//   - Field widths for the binary hh:mm:ss display path.
//   - Legal maxima for the minute and second fields.
//   - Timer control FSM state encoding.
//   - A clamp helper for the 6-bit minute/second fields.
package timer_pkg;

  localparam int unsigned HOUR_W = 5;
  localparam int unsigned MIN_W  = 6;
  localparam int unsigned SEC_W  = 6;

  localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
  localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StPause,
    StDone
  } timer_state_e;

  // Saturate a 6-bit minute/second field to its legal maximum.
  function automatic logic [5:0] clamp_field(input logic [5:0] value, input logic [5:0] limit);
    return (value > limit) ? limit : value;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV enabled cycles.
//   clk      : system clock
//   reset    : asynchronous, active-high reset (count -> 0)
//   enable_i : advance the count this cycle; count holds when low
//   clear_i  : synchronously zero the count (wins over enable_i)
//   tick_o   : high in the enabled cycle whose count is TICK_DIV-1
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic enable_i,
  input  logic clear_i,
  output logic tick_o
);

  localparam int unsigned    TickW    = $clog2(TICK_DIV);
  localparam logic [TickW-1:0] TickLast = TickW'(TICK_DIV - 1);

  logic [TickW-1:0] count_q, count_d;
  logic             at_last;

  assign at_last = (count_q == TickLast);
  assign tick_o  = enable_i & ~clear_i & at_last;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = at_last ? '0 : count_q + TickW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// hh:mm:ss countdown timer: loads a clamped preset, decrements once per TICK_DIV clocks
// while running, and stops in DONE on reaching 00:00:00.
//   clk, reset                 : clock, asynchronous active-high reset
//   load_i / start_i / stop_i  : level-sampled controls, priority load > stop > start
//   preset_{hour,min,sec}_i    : preset value, clamped per field on load
//   {hour,min,sec}_o           : remaining time (registered)
//   running_o                  : state is RUN
//   done_o                     : one-cycle pulse when the count reaches zero
//   expired_o                  : state is DONE
module countdown_timer
  import timer_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1024,
  parameter int unsigned MAX_HOUR = 23
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic [HOUR_W-1:0] preset_hour_i,
  input  logic [MIN_W-1:0]  preset_min_i,
  input  logic [SEC_W-1:0]  preset_sec_i,
  output logic [HOUR_W-1:0] hour_o,
  output logic [MIN_W-1:0]  min_o,
  output logic [SEC_W-1:0]  sec_o,
  output logic              running_o,
  output logic              done_o,
  output logic              expired_o
);

  localparam logic [HOUR_W-1:0] MaxHour = HOUR_W'(MAX_HOUR);

  timer_state_e      state_q, state_d;
  logic [HOUR_W-1:0] hour_q, hour_d;
  logic [MIN_W-1:0]  min_q, min_d;
  logic [SEC_W-1:0]  sec_q, sec_d;
  logic              done_q, done_d;
  logic              running_q, expired_q;

  logic              presc_en, presc_clr, tick;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .enable_i (presc_en),
    .clear_i  (presc_clr),
    .tick_o   (tick)
  );

  // Clamped preset.
  logic [HOUR_W-1:0] ld_hour;
  logic [MIN_W-1:0]  ld_min;
  logic [SEC_W-1:0]  ld_sec;

  assign ld_hour = (preset_hour_i > MaxHour) ? MaxHour : preset_hour_i;
  assign ld_min  = clamp_field(preset_min_i, MIN_MAX);
  assign ld_sec  = clamp_field(preset_sec_i, SEC_MAX);

  // Borrow-chain decrement. Only used in RUN, where the count is never zero.
  logic [HOUR_W-1:0] dec_hour;
  logic [MIN_W-1:0]  dec_min;
  logic [SEC_W-1:0]  dec_sec;
  logic              dec_zero, count_zero;

  always_comb begin
    dec_hour = hour_q;
    dec_min  = min_q;
    dec_sec  = sec_q;
    if (sec_q != '0) begin
      dec_sec = sec_q - SEC_W'(1);
    end else if (min_q != '0) begin
      dec_min = min_q - MIN_W'(1);
      dec_sec = SEC_MAX;
    end else begin
      dec_hour = hour_q - HOUR_W'(1);
      dec_min  = MIN_MAX;
      dec_sec  = SEC_MAX;
    end
  end

  assign dec_zero   = (dec_hour == '0) && (dec_min == '0) && (dec_sec == '0);
  assign count_zero = (hour_q == '0) && (min_q == '0) && (sec_q == '0);

  always_comb begin
    state_d   = state_q;
    hour_d    = hour_q;
    min_d     = min_q;
    sec_d     = sec_q;
    done_d    = 1'b0;
    presc_en  = 1'b0;
    presc_clr = 1'b0;

    case (state_q)
      StIdle: begin
        if (load_i) begin
          hour_d    = ld_hour;
          min_d     = ld_min;
          sec_d     = ld_sec;
          presc_clr = 1'b1;
        end else if (start_i && !count_zero) begin
          state_d = StRun;
        end
      end
      StRun: begin
        // Prescaler is left disabled on stop so its phase survives the pause.
        if (stop_i) begin
          state_d = StPause;
        end else begin
          presc_en = 1'b1;
          if (tick) begin
            hour_d = dec_hour;
            min_d  = dec_min;
            sec_d  = dec_sec;
            if (dec_zero) begin
              state_d = StDone;
              done_d  = 1'b1;
            end
          end
        end
      end
      StPause: begin
        if (load_i) begin
          hour_d    = ld_hour;
          min_d     = ld_min;
          sec_d     = ld_sec;
          presc_clr = 1'b1;
          state_d   = StIdle;
        end else if (start_i) begin
          state_d = StRun;
        end
      end
      StDone: begin
        if (load_i) begin
          hour_d    = ld_hour;
          min_d     = ld_min;
          sec_d     = ld_sec;
          presc_clr = 1'b1;
          state_d   = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      hour_q    <= '0;
      min_q     <= '0;
      sec_q     <= '0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hour_q    <= hour_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      done_q    <= done_d;
      running_q <= (state_d == StRun);
      expired_q <= (state_d == StDone);
    end
  end

  assign hour_o    = hour_q;
  assign min_o     = min_q;
  assign sec_o     = sec_q;
  assign running_o = running_q;
  assign done_o    = done_q;
  assign expired_o = expired_q;

endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;

  localparam int unsigned TickDiv = 4;
  localparam int unsigned MaxHour = 23;

  logic       clk = 1'b0;
  logic       reset;
  logic       load, start, stop;
  logic [4:0] preset_hour;
  logic [5:0] preset_min, preset_sec;
  logic [4:0] hour;
  logic [5:0] min, sec;
  logic       running, done, expired;

  int total = 0;
  int bad   = 0;

  countdown_timer #(
    .TICK_DIV (TickDiv),
    .MAX_HOUR (MaxHour)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .load_i        (load),
    .start_i       (start),
    .stop_i        (stop),
    .preset_hour_i (preset_hour),
    .preset_min_i  (preset_min),
    .preset_sec_i  (preset_sec),
    .hour_o        (hour),
    .min_o         (min),
    .sec_o         (sec),
    .running_o     (running),
    .done_o        (done),
    .expired_o     (expired)
  );

  always #5 clk = ~clk;

  // Reference model: remaining time as a plain number of seconds.
  localparam int MIdle = 0, MRun = 1, MPause = 2, MDone = 3;
  int m_total, m_mode, m_phase;
  bit m_done;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    m_total = 0;
    m_mode  = MIdle;
    m_phase = 0;
    m_done  = 1'b0;
  endtask

  task automatic model_load(input int ph, input int pm, input int ps);
    m_total = imin(ph, MaxHour) * 3600 + imin(pm, 59) * 60 + imin(ps, 59);
    m_phase = 0;
  endtask

  task automatic model_step(input bit l, input bit s, input bit p,
                            input int ph, input int pm, input int ps);
    m_done = 1'b0;
    case (m_mode)
      MIdle: begin
        if (l) model_load(ph, pm, ps);
        else if (s && m_total != 0) m_mode = MRun;
      end
      MRun: begin
        if (p) begin
          m_mode = MPause;
        end else if (m_phase == TickDiv - 1) begin
          m_phase = 0;
          m_total = m_total - 1;
          if (m_total == 0) begin
            m_mode = MDone;
            m_done = 1'b1;
          end
        end else begin
          m_phase = m_phase + 1;
        end
      end
      MPause: begin
        if (l) begin
          model_load(ph, pm, ps);
          m_mode = MIdle;
        end else if (s) begin
          m_mode = MRun;
        end
      end
      default: begin
        if (l) begin
          model_load(ph, pm, ps);
          m_mode = MIdle;
        end
      end
    endcase
  endtask

  task automatic check_out(input string name, input int eh, input int em, input int es,
                           input bit er, input bit ed, input bit ee);
    logic [19:0] act, exp_v;
    act   = {hour, min, sec, running, done, expired};
    exp_v = {5'(eh), 6'(em), 6'(es), er, ed, ee};
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0d:%0d:%0d r=%b d=%b e=%b, want %0d:%0d:%0d r=%b d=%b e=%b",
               name, hour, min, sec, running, done, expired, eh, em, es, er, ed, ee);
    end
  endtask

  task automatic check_model(input string name);
    check_out(name, m_total / 3600, (m_total / 60) % 60, m_total % 60,
              m_mode == MRun, m_done, m_mode == MDone);
  endtask

  // Drive one cycle of inputs, step the model at the edge, compare just after it.
  task automatic apply(input bit l, input bit s, input bit p,
                       input int ph, input int pm, input int ps);
    load        = l;
    start       = s;
    stop        = p;
    preset_hour = 5'(ph);
    preset_min  = 6'(pm);
    preset_sec  = 6'(ps);
    @(posedge clk);
    model_step(l, s, p, ph, pm, ps);
    #1;
    check_model("model");
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) apply(1'b0, 1'b0, 1'b0, 0, 0, 0);
  endtask

  typedef struct {
    bit l, s, p;
    int ph, pm, ps;
    int eh, em, es;
    bit er, ed, ee;
  } vec_t;

  function automatic vec_t mk(input bit l, input bit s, input bit p,
                              input int ph, input int pm, input int ps,
                              input int eh, input int em, input int es,
                              input bit er, input bit ed, input bit ee);
    vec_t v;
    v.l = l;  v.s = s;  v.p = p;
    v.ph = ph; v.pm = pm; v.ps = ps;
    v.eh = eh; v.em = em; v.es = es;
    v.er = er; v.ed = ed; v.ee = ee;
    return v;
  endfunction

  vec_t tbl[18];

  initial begin
    // Basic 3-second countdown, DONE behaviour, clamping, load+start priority.
    tbl[0]  = mk(1, 0, 0, 0, 0, 3,   0, 0, 3,  0, 0, 0);
    tbl[1]  = mk(0, 1, 0, 0, 0, 0,   0, 0, 3,  1, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0,   0, 0, 3,  1, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0,   0, 0, 3,  1, 0, 0);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0,   0, 0, 3,  1, 0, 0);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0,   0, 0, 2,  1, 0, 0);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0,   0, 0, 2,  1, 0, 0);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0,   0, 0, 2,  1, 0, 0);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0,   0, 0, 2,  1, 0, 0);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0,   0, 0, 1,  1, 0, 0);
    tbl[10] = mk(0, 0, 0, 0, 0, 0,   0, 0, 1,  1, 0, 0);
    tbl[11] = mk(0, 0, 0, 0, 0, 0,   0, 0, 1,  1, 0, 0);
    tbl[12] = mk(0, 0, 0, 0, 0, 0,   0, 0, 1,  1, 0, 0);
    tbl[13] = mk(0, 0, 0, 0, 0, 0,   0, 0, 0,  0, 1, 1);
    tbl[14] = mk(0, 0, 0, 0, 0, 0,   0, 0, 0,  0, 0, 1);
    tbl[15] = mk(0, 1, 1, 0, 0, 0,   0, 0, 0,  0, 0, 1);
    tbl[16] = mk(1, 0, 0, 31, 63, 60, 23, 59, 59, 0, 0, 0);
    tbl[17] = mk(1, 1, 0, 0, 0, 2,   0, 0, 2,  0, 0, 0);

    reset = 1'b1;
    load = 1'b0; start = 1'b0; stop = 1'b0;
    preset_hour = '0; preset_min = '0; preset_sec = '0;
    model_reset();
    #12;
    check_out("reset_state", 0, 0, 0, 0, 0, 0);
    reset = 1'b0;

    for (int i = 0; i < 18; i++) begin
      apply(tbl[i].l, tbl[i].s, tbl[i].p, tbl[i].ph, tbl[i].pm, tbl[i].ps);
      check_out($sformatf("vec%0d", i), tbl[i].eh, tbl[i].em, tbl[i].es,
                tbl[i].er, tbl[i].ed, tbl[i].ee);
    end

    // Load ignored while running; start+stop pauses; load in PAUSE returns to IDLE.
    apply(0, 1, 0, 0, 0, 0);
    apply(1, 0, 0, 0, 0, 9);
    check_out("load_in_run", 0, 0, 2, 1, 0, 0);
    apply(0, 1, 1, 0, 0, 0);
    check_out("start_stop_pause", 0, 0, 2, 0, 0, 0);
    apply(1, 0, 0, 1, 0, 0);
    check_out("load_in_pause", 1, 0, 0, 0, 0, 0);

    // Borrow through hours, then through minutes.
    apply(0, 1, 0, 0, 0, 0);
    nop(3);
    check_out("borrow_h_before", 1, 0, 0, 1, 0, 0);
    nop(1);
    check_out("borrow_h", 0, 59, 59, 1, 0, 0);
    apply(0, 0, 1, 0, 0, 0);
    apply(1, 0, 0, 0, 1, 0);
    apply(0, 1, 0, 0, 0, 0);
    nop(4);
    check_out("borrow_m", 0, 0, 59, 1, 0, 0);

    // Pause after two ticks of phase; resume needs only two more cycles.
    apply(0, 0, 1, 0, 0, 0);
    apply(1, 0, 0, 0, 0, 5);
    apply(0, 1, 0, 0, 0, 0);
    nop(2);
    apply(0, 0, 1, 0, 0, 0);
    check_out("paused", 0, 0, 5, 0, 0, 0);
    nop(10);
    check_out("pause_hold", 0, 0, 5, 0, 0, 0);
    apply(0, 1, 0, 0, 0, 0);
    check_out("resume", 0, 0, 5, 1, 0, 0);
    nop(1);
    check_out("resume_p1", 0, 0, 5, 1, 0, 0);
    nop(1);
    check_out("resume_dec", 0, 0, 4, 1, 0, 0);

    // Async reset mid-run with the prescaler part-way through a second.
    apply(0, 0, 1, 0, 0, 0);
    apply(1, 0, 0, 0, 0, 3);
    apply(0, 1, 0, 0, 0, 0);
    nop(6);
    check_out("pre_reset", 0, 0, 2, 1, 0, 0);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_out("async_reset", 0, 0, 0, 0, 0, 0);
    #2 reset = 1'b0;
    apply(0, 1, 0, 0, 0, 0);
    check_out("start_zero", 0, 0, 0, 0, 0, 0);
    apply(1, 0, 0, 0, 0, 1);
    apply(0, 1, 0, 0, 0, 0);
    nop(3);
    check_out("last_sec", 0, 0, 1, 1, 0, 0);
    nop(1);
    check_out("last_done", 0, 0, 0, 0, 1, 1);

    // Randomized traffic against the model (apply compares every cycle).
    for (int i = 0; i < 3000; i++) begin
      bit l, s, p;
      int ph, pm, ps;
      l = ($urandom_range(0, 99) < 6);
      s = ($urandom_range(0, 3) == 0);
      p = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 1) == 0) begin
        ph = 0;
        pm = 0;
        ps = $urandom_range(0, 6);
      end else begin
        ph = $urandom_range(0, 31);
        pm = $urandom_range(0, 63);
        ps = $urandom_range(0, 63);
      end
      apply(l, s, p, ph, pm, ps);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
